bcd_bin_converter: RTL
======================

Name: bcd_bin_converter

Overview:
- Parametrised, bidirectional iterative converter using the double-dabble algorithm.
- Mode 0 converts packed BCD to binary (reverse double-dabble). Mode 1 converts binary to packed BCD (forward double-dabble).
- Performs one shift-and-correct iteration per clock, with a start/busy/done handshake.
- Flags invalid BCD digits and binary values too large for the configured digit count.
- Serves the display and keypad datapaths as the general replacement for fixed-width, single-direction converters.

Parameters:
- DIGITS, 3: number of BCD digits. BCD bus width is 4*DIGITS.
- BIN_W, 10: binary width and iteration count. Must satisfy 2**BIN_W > 10**DIGITS-1. Out-of-range settings are a synthesis-time error.
- MAXV (localparam), 10**DIGITS-1: largest representable value.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- st  in  1  start request; sampled only in IDLE.
- mode  in  1  0 = BCD→binary, 1 = binary→BCD; captured with st.
- bcd_in  in  4*DIGITS  packed BCD operand; digit 0 is bits [3:0].
- bin_in  in  BIN_W  binary operand.
- bin_out  out  BIN_W  binary result; registered.
- bcd_out  out  4*DIGITS  BCD result; registered.
- busy  out  1  high from the accept edge until done.
- done  out  1  single-cycle completion pulse.
- err  out  1  operand invalid; valid only while done is high, and held afterwards.

Behaviour:
- Reset, asynchronous and immediate:
  - state = IDLE, iteration counter = 0, working registers = 0.
  - bin_out = 0, bcd_out = 0, busy = 0, done = 0, err = 0.
  - A reset asserted mid-run aborts the run. No done pulse is produced.
- State machine:
  - IDLE → RUN when st = 1.
  - IDLE → DONE when st = 1 and the operand is invalid.
  - RUN → DONE after BIN_W iterations.
  - DONE → IDLE unconditionally.
- Accept edge (IDLE, st = 1):
  - Latch mode.
  - Load the BCD working register with bcd_in (mode 0) or 0 (mode 1).
  - Load the binary working register with 0 (mode 0) or bin_in (mode 1).
  - Set counter = 0 and clear err.
- Validity checks at accept:
  - Mode 0: any digit of bcd_in > 9 makes the operand invalid.
  - Mode 1: bin_in > MAXV makes the operand invalid.
  - Invalid operand: next state is DONE, err = 1, and the result outputs are written to 0.
- Mode 0 iteration, per RUN edge:
  - Shift the concatenation {bcd, bin} right by 1; the BCD LSB enters the binary MSB.
  - Then, in every post-shift digit ≥ 8, subtract 3.
  - Both steps happen combinationally within the same cycle.
- Mode 1 iteration, per RUN edge:
  - In every BCD digit ≥ 5, add 3.
  - Then shift the concatenation {bcd, bin} left by 1; the binary MSB enters the BCD LSB.
  - Both steps happen combinationally within the same cycle.
- Counter:
  - Increments on each RUN edge.
  - On the edge performing iteration BIN_W, the next state is DONE and the final working value is written to bin_out (mode 0) or bcd_out (mode 1).
  - The other output is written to 0.
- Timing:
  - Valid operand: done is high during the cycle following the BIN_W-th RUN edge. Latency is BIN_W+1 edges from the accept edge.
  - Invalid operand: done is high the cycle after the accept edge.
  - busy is high in RUN and low in IDLE and DONE.
  - done is high only in DONE.
- st while busy or in DONE is ignored, with no queueing. st held high in IDLE starts a new run each time IDLE is reached.
- Operands are not required to be held after the accept edge.
- Outputs and err hold their values until the next accept or reset.
- No wrap-around is possible: digit corrections never overflow a nibble given the validity checks.

Test Plan (DIGITS=3, BIN_W=10):
- Mode 0, bcd_in=12'h255, pulse st → busy for 10 cycles, done pulses once 11 edges after accept, bin_out=10'd255, bcd_out=0, err=0.
- Mode 0, bcd_in=12'h999 → bin_out=10'd999. Mode 0, bcd_in=12'h000 → bin_out=0, err=0.
- Mode 1, bin_in=10'd1000 → done one cycle after accept, err=1, outputs 0. Mode 1, bin_in=10'd999 → bcd_out=12'h999 after 11 edges.
- Mode 0, bcd_in=12'h1A3 → err=1, done one cycle after accept, bin_out=0. The next valid run (12'h042) clears err and gives bin_out=42.
- st pulsed again at iteration 4 of a run (bin_in=10'd123, mode 1) with a different operand → ignored; bcd_out=12'h123, exactly one done.
- rst asserted mid-run at iteration 5 → all outputs 0 immediately, no done pulse. The next run after release converts correctly.

Source files
------------

// File: rtl/bcd_bin_converter_if.sv
// Handshake and operand/result bundle for the bidirectional BCD/binary converter.
interface bcd_bin_converter_if #(
   parameter int unsigned DIGITS = 3,
   parameter int unsigned BIN_W  = 10
);
   logic                  st;
   logic                  mode;
   logic [4*DIGITS-1:0]   bcd_in;
   logic [BIN_W-1:0]      bin_in;
   logic [BIN_W-1:0]      bin_out;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  busy;
   logic                  done;
   logic                  err;

   modport master (
      output st, mode, bcd_in, bin_in,
      input  bin_out, bcd_out, busy, done, err
   );

   modport slave (
      input  st, mode, bcd_in, bin_in,
      output bin_out, bcd_out, busy, done, err
   );
endinterface

// File: rtl/bcd_bin_converter.sv
// Iterative double-dabble converter: mode 0 BCD->binary (reverse), mode 1 binary->BCD
// (forward), one shift-and-correct step per clock.
module bcd_bin_converter #(
   parameter int unsigned DIGITS = 3,
   parameter int unsigned BIN_W  = 10
) (
   input logic                 clk,
   input logic                 rst,
   bcd_bin_converter_if.slave  bus
);
   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CAT_W = BCD_W + BIN_W;
   localparam int unsigned CNT_W = $clog2(BIN_W + 1);

   function automatic longint unsigned pow10(input int unsigned n);
      longint unsigned p;
      p = 1;
      for (int unsigned i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   localparam longint unsigned MAXV = pow10(DIGITS) - 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

   if (DIGITS < 1 || DIGITS > 18 || BIN_W < 1 || BIN_W > 63 || (64'd1 << BIN_W) <= MAXV)
   begin : g_bad_params
      $error("bcd_bin_converter: BIN_W too small for DIGITS or parameters out of range");
   end

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e             r_state, w_state_nxt;
   logic               r_mode, w_mode_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [BCD_W-1:0]   r_bcd, w_bcd_nxt;
   logic [BIN_W-1:0]   r_bin, w_bin_nxt;
   logic [BIN_W-1:0]   r_bin_out, w_bin_out_nxt;
   logic [BCD_W-1:0]   r_bcd_out, w_bcd_out_nxt;
   logic               r_err, w_err_nxt;

   logic [CAT_W-1:0]   w_rev;
   logic [CAT_W-1:0]   w_fwd;
   logic [BCD_W-1:0]   w_adj;
   logic               w_bcd_bad;
   logic               w_bin_bad;
   logic               w_bad;

   // Operand validity, evaluated on the raw inputs at the accept edge
   always_comb begin
      w_bcd_bad = 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (bus.bcd_in[4*i +: 4] > 4'd9) w_bcd_bad = 1'b1;
      end
      w_bin_bad = 64'(bus.bin_in) > MAXV;
      w_bad     = bus.mode ? w_bin_bad : w_bcd_bad;
   end

   // One iteration in each direction; only the one matching r_mode is used
   always_comb begin
      w_rev = {r_bcd, r_bin} >> 1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (w_rev[BIN_W + 4*i +: 4] >= 4'd8)
            w_rev[BIN_W + 4*i +: 4] = w_rev[BIN_W + 4*i +: 4] - 4'd3;
      end
      w_adj = r_bcd;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (w_adj[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = w_adj[4*i +: 4] + 4'd3;
      end
      w_fwd = {w_adj, r_bin} << 1;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_mode_nxt    = r_mode;
      w_cnt_nxt     = r_cnt;
      w_bcd_nxt     = r_bcd;
      w_bin_nxt     = r_bin;
      w_bin_out_nxt = r_bin_out;
      w_bcd_out_nxt = r_bcd_out;
      w_err_nxt     = r_err;
      unique case (r_state)
         StIdle: begin
            if (bus.st) begin
               w_mode_nxt = bus.mode;
               w_cnt_nxt  = '0;
               w_err_nxt  = 1'b0;
               w_bcd_nxt  = bus.mode ? '0 : bus.bcd_in;
               w_bin_nxt  = bus.mode ? bus.bin_in : '0;
               if (w_bad) begin
                  w_state_nxt   = StDone;
                  w_err_nxt     = 1'b1;
                  w_bin_out_nxt = '0;
                  w_bcd_out_nxt = '0;
               end else begin
                  w_state_nxt = StRun;
               end
            end
         end
         StRun: begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_mode) begin
               w_bcd_nxt = w_fwd[BIN_W +: BCD_W];
               w_bin_nxt = w_fwd[BIN_W-1:0];
            end else begin
               w_bcd_nxt = w_rev[BIN_W +: BCD_W];
               w_bin_nxt = w_rev[BIN_W-1:0];
            end
            if (r_cnt == LAST) begin
               w_state_nxt   = StDone;
               w_bin_out_nxt = r_mode ? '0 : w_rev[BIN_W-1:0];
               w_bcd_out_nxt = r_mode ? w_fwd[BIN_W +: BCD_W] : '0;
            end
         end
         StDone:  w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= StIdle;
         r_mode    <= 1'b0;
         r_cnt     <= '0;
         r_bcd     <= '0;
         r_bin     <= '0;
         r_bin_out <= '0;
         r_bcd_out <= '0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_mode    <= w_mode_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bcd     <= w_bcd_nxt;
         r_bin     <= w_bin_nxt;
         r_bin_out <= w_bin_out_nxt;
         r_bcd_out <= w_bcd_out_nxt;
         r_err     <= w_err_nxt;
      end
   end

   assign bus.bin_out = r_bin_out;
   assign bus.bcd_out = r_bcd_out;
   assign bus.busy    = (r_state == StRun);
   assign bus.done    = (r_state == StDone);
   assign bus.err     = r_err;
endmodule
